ram: RTL and testbench

- Single-port synchronous RAM: 256 words x 8 bits, the data/scratch memory of the 8-bit crypto processor.
- One shared address bus serves both write and read, selected by `we`.
- Read data is registered on `Qout`.
- Asynchronous active-high reset clears the whole array and the output register.

---
 rtl/ram.sv | 47 ++++
 tb/tb_ram.sv | 113 +++++++++++
 2 files changed

// File: rtl/ram.sv
// rtl/ram.sv - 256x8 single-port synchronous RAM with write-through, registered read and async clear
module ram #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] Qout
);

  // Flop-based array so the whole memory can be cleared asynchronously.
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DATA_WIDTH-1:0] r_qout;
  logic [DATA_WIDTH-1:0] w_rd_word;

  // Read mux; addr width matches log2(DEPTH) so every address is in range.
  assign w_rd_word = r_mem[addr];

  // Array update: reset clears every word and overrides a coincident write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (we) begin
      r_mem[addr] <= data;
    end
  end

  // Output register: a write shows the new data, a read shows the stored word one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qout <= '0;
    end else if (we) begin
      r_qout <= data;
    end else begin
      r_qout <= w_rd_word;
    end
  end

  assign Qout = r_qout;

endmodule

// File: tb/tb_ram.sv
// tb/tb_ram.sv - directed self-checking bench for ram
module tb_ram;

  logic       clk;
  logic       rst;
  logic [7:0] data;
  logic [7:0] addr;
  logic       we;
  logic [7:0] Qout;

  int n_cmp;
  int n_fail;

  ram dut (
    .clk  (clk),
    .rst  (rst),
    .data (data),
    .addr (addr),
    .we   (we),
    .Qout (Qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] exp);
    n_cmp++;
    assert (Qout === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, Qout, exp);
    end
  endtask

  // Drive one operation, let the rising edge take it, then check 1 time unit later.
  task automatic op(input logic w, input logic [7:0] a, input logic [7:0] d,
                    input string tag, input logic [7:0] exp);
    we   = w;
    addr = a;
    data = d;
    @(posedge clk);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst  = 1'b0;
    we   = 1'b0;
    addr = 8'h00;
    data = 8'h00;

    // Reset asserted away from a clock edge; output clears without a clock.
    #2 rst = 1'b1;
    #1 chk("reset_async", 8'h00);
    op(1'b0, 8'd0, 8'h00, "reset_hold_rd0", 8'h00);
    op(1'b1, 8'd7, 8'h77, "reset_hold_wr", 8'h00);
    rst = 1'b0;

    // Never-written words read zero; first edge after release is a real operation.
    op(1'b0, 8'd0,   8'h00, "rd0_after_rst",   8'h00);
    op(1'b0, 8'd5,   8'h00, "rd5_after_rst",   8'h00);
    op(1'b0, 8'd255, 8'h00, "rd255_after_rst", 8'h00);
    op(1'b0, 8'd7,   8'h00, "rd7_wr_in_rst",   8'h00);

    // Consecutive writes with write-through, then reads back.
    for (int i = 0; i < 6; i++) begin
      op(1'b1, 8'(i), 8'(i + 1), $sformatf("wt_addr%0d", i), 8'(i + 1));
    end
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 8'(i), 8'hEE, $sformatf("rd_addr%0d", i), 8'(i + 1));
    end

    // Top address behaves as a normal word; neighbour untouched.
    op(1'b1, 8'd255, 8'hA5, "wr255_wt", 8'hA5);
    op(1'b0, 8'd255, 8'h00, "rd255",    8'hA5);
    op(1'b0, 8'd254, 8'h00, "rd254",    8'h00);

    // Read-after-write on the very next cycle.
    op(1'b1, 8'd10, 8'h3C, "wr10_wt", 8'h3C);
    op(1'b0, 8'd10, 8'h00, "rd10",    8'h3C);

    // Address changes between edges do not reach Qout until the next edge.
    op(1'b0, 8'd0, 8'h00, "rd0_again", 8'h01);
    addr = 8'd1;
    #2 chk("hold_after_addr1", 8'h01);
    addr = 8'd2;
    data = 8'h99;
    #1 chk("hold_after_addr2", 8'h01);
    @(posedge clk);
    #1 chk("rd2_at_edge", 8'h03);

    // Mid-cycle async reset clears output before the next edge and wipes memory.
    #2 rst = 1'b1;
    #1 chk("mid_cycle_rst", 8'h00);
    op(1'b1, 8'd3, 8'hFF, "wr_during_rst", 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      op(1'b0, 8'(i), 8'h00, $sformatf("rd_cleared%0d", i), 8'h00);
    end
    op(1'b0, 8'd255, 8'h00, "rd255_cleared", 8'h00);
    op(1'b0, 8'd10,  8'h00, "rd10_cleared",  8'h00);

    // Normal operation resumes after the reset.
    op(1'b1, 8'd3, 8'h5A, "wr3_post", 8'h5A);
    op(1'b0, 8'd4, 8'h00, "rd4_post", 8'h00);
    op(1'b0, 8'd3, 8'h00, "rd3_post", 8'h5A);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
